gpio_input_sync: RTL
====================

# gpio_input_sync

Input-side counterpart to the PIO output arbitration path. Takes the 32 raw GPIO pad inputs and resynchronises them into the PIO clock domain, with an optional per-pin glitch filter. It also records sticky rising and falling edge flags per pin. Its outputs are the pin values all cores and FSMs read for IN, WAIT and JMP PIN, plus edge events for status and interrupt logic.

## Interface
Parameters:
- NUM_PINS, 32, number of GPIO pins handled
- SYNC_STAGES, 2, flip-flop stages in each synchroniser chain (legal values ≥ 2)
- FILTER_W, 4, width of the glitch-filter length field and of each per-pin counter

Ports:
- clk  input  1  PIO system clock
- rst  input  1  asynchronous reset, active-high
- gpio_input  input  NUM_PINS  raw pad inputs, asynchronous to clk
- sync_bypass  input  NUM_PINS  per-pin: 1 = skip synchroniser chain (pin already synchronous)
- filter_len  input  FILTER_W  global glitch-filter length N; 0 = no filtering
- edge_clear  input  NUM_PINS  per-pin: 1-cycle pulse clears both edge flags of that pin
- gpio_sync  output  NUM_PINS  synchronised, filtered pin values
- rise_flag  output  NUM_PINS  sticky 0→1 event seen on gpio_sync
- fall_flag  output  NUM_PINS  sticky 1→0 event seen on gpio_sync

## Operation
Each pin is processed independently; there is no cross-pin interaction.

- **Synchroniser:**
  - SYNC_STAGES-deep flop chain per pin.
  - Stage value s = last stage of the chain, or gpio_input[i] directly when sync_bypass[i] = 1.
  - The chain keeps shifting even while bypassed.
- **Filter state:** per pin, filtered register f[i] drives gpio_sync[i], plus counter cnt[i] (FILTER_W bits).
- **Filter update, each cycle:**
  - s == f: cnt ← 0.
  - s != f and cnt ≥ filter_len: f ← s, cnt ← 0.
  - s != f and cnt < filter_len: cnt ← cnt + 1.
  - Result: a change must persist for N+1 consecutive cycles to propagate.
  - A shorter pulse is dropped and its count is discarded.
- **filter_len changes mid-count:** the new value is compared against the current cnt at the next edge. If cnt already ≥ new N, f updates immediately.
- **Edge flags:**
  - rise_flag[i] is set on the cycle f[i] goes 0→1.
  - fall_flag[i] is set on the cycle f[i] goes 1→0.
  - Flags hold until edge_clear[i].
  - Set and clear in the same cycle: set wins, and the flag stays 1.
  - edge_clear clears both flags of the pin.
- **Reset:**
  - The synchroniser chain, f, cnt, rise_flag and fall_flag are all 0.
  - Reset is asynchronous, effective immediately, including mid-filter.
  - A pin held high through reset produces a rise_flag after the normal latency once reset deasserts.

## Timing
- **Latency, gpio_input edge → gpio_sync, filter_len = 0:**
  - Non-bypassed: SYNC_STAGES + 1 clk edges (3 at default).
  - Bypassed: 1 edge.
- **Latency with filter_len = N:** add N edges to the above, provided the input is stable.
- **Edge flags:** rise_flag/fall_flag assert on the same edge as the gpio_sync transition.
- **edge_clear:** takes effect on the next edge, with set-priority as above.
- All outputs are registered; there is no combinational path from any input to any output.
- Inputs other than gpio_input are synchronous to clk.

## Configuration
Macro: GPIO_IN_FILTER_EN.
- **Defined:** glitch filter is present as described.
- **Undefined:**
  - No cnt registers.
  - filter_len is ignored.
  - f ← s every cycle, so latency is fixed at SYNC_STAGES + 1 (1 when bypassed).
  - Edge flags and bypass behave identically.

## Test plan
- **Reset and basic latency:** reset, then gpio_input[0] 0→1 with no bypass and filter_len = 0 → gpio_sync[0] = 1 exactly 3 edges later; rise_flag[0] = 1 on the same edge.
- **Bypass:** sync_bypass[5] = 1, toggle gpio_input[5] → gpio_sync[5] follows after 1 edge; pin 6 (not bypassed) toggled simultaneously → follows after 3 edges.
- **Glitch filter:** filter_len = 3.
  - 3-cycle high pulse on pin 2 → gpio_sync[2] stays 0 and no flags set.
  - 4-cycle pulse → gpio_sync[2] = 1 at edge 3 + 3 = 6 after the input edge.
- **Flag clear priority:**
  - Fall event on pin 9 coincident with edge_clear[9] → fall_flag[9] remains 1.
  - A later edge_clear[9] alone → both flags 0.
- **Async reset mid-filter:** filter_len = 7, assert rst while cnt is mid-count on pin 1 → all outputs 0 immediately (before the next clk edge); after release, an input held high propagates after the full 3 + 7 edges.
- **Macro off:** build without GPIO_IN_FILTER_EN, filter_len = 15, 1-cycle pulse on pin 31 → gpio_sync[31] pulses for 1 cycle after 3 edges, and rise_flag[31] and fall_flag[31] both set.

Source files
------------

// File: rtl/gpio_input_sync.sv
// gpio_input_sync: resynchronises GPIO pads into clk, with optional per-pin glitch filter
// (enabled by defining GPIO_IN_FILTER_EN) and sticky per-pin rise/fall edge flags.
module gpio_input_sync #(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] gpio_input,
    input  logic [NUM_PINS-1:0] sync_bypass,
    input  logic [FILTER_W-1:0] filter_len,
    input  logic [NUM_PINS-1:0] edge_clear,
    output logic [NUM_PINS-1:0] gpio_sync,
    output logic [NUM_PINS-1:0] rise_flag,
    output logic [NUM_PINS-1:0] fall_flag
);
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] s;
    logic [NUM_PINS-1:0] f_next;

    // The chain shifts regardless of bypass so un-bypassing never exposes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= gpio_input;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = (sync_bypass & gpio_input) | (~sync_bypass & sync_q[SYNC_STAGES-1]);

`ifdef GPIO_IN_FILTER_EN
    logic [FILTER_W-1:0] cnt [NUM_PINS];

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_filt
        assign f_next[i] = (s[i] != gpio_sync[i] && cnt[i] >= filter_len) ? s[i] : gpio_sync[i];
        // Any return to the filtered value discards the partial count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt[i] <= '0;
            else cnt[i] <= (s[i] == gpio_sync[i] || cnt[i] >= filter_len) ? '0 : cnt[i] + 1'b1;
        end
    end
`else
    logic unused_filter_len;

    assign unused_filter_len = ^filter_len;
    assign f_next = s;
`endif

    // Set beats clear so an edge coincident with edge_clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_sync <= '0;
            rise_flag <= '0;
            fall_flag <= '0;
        end else begin
            gpio_sync <= f_next;
            rise_flag <= (rise_flag & ~edge_clear) | (f_next & ~gpio_sync);
            fall_flag <= (fall_flag & ~edge_clear) | (~f_next & gpio_sync);
        end
    end
endmodule
